insn_encoder: RTL and testbench
===============================

Name: insn_encoder

Overview:
Assembles 32-bit RVV instruction words from field bundles. Covers arithmetic (OP-V), config (vset*) and vector memory formats. Field names match the decoder's outputs, so a word built here decodes back to the same fields. Words are buffered in a small FIFO and issued over a valid/ready stream toward the vector unit; illegal bundles are flagged and dropped. Used by the test-sequence generator and the scalar-to-vector issue path.

Parameters:
INSN_WIDTH, 32, instruction word width; only 32 is supported
DEPTH, 4, FIFO entries; power of two, at least 2
CNT_WIDTH, 16, width of the issued-word counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  field bundle valid
in_ready  out  1  bundle accepted when in_valid & in_ready
fmt  in  2  0=ARITH, 1=CFG, 2=MEM, 3=reserved
opcode_mjr  in  7  major opcode; used by MEM only
opcode_mnr  in  3  funct3 for ARITH
dest  in  5  rd/vd/vs3
src_1  in  5  rs1/vs1/imm/uimm
src_2  in  5  rs2/vs2/lumop/sumop
width  in  3  MEM width field
mop  in  2  MEM addressing mode
mew  in  1  MEM extended width
nf  in  3  MEM field count
vtype_11  in  11  vsetvli zimm
vtype_10  in  10  vsetivli zimm
cfg_type  in  2  0x=vsetvli, 11=vsetivli, 10=vsetvl
vm  in  1  mask bit
funct6  in  6  ARITH funct6
out_valid  out  1  head word valid
out_ready  in  1  consumer ready
out_insn  out  INSN_WIDTH  head instruction word
fifo_count  out  $clog2(DEPTH)+1  occupancy
err  out  1  one-cycle pulse: the previously accepted bundle was illegal and dropped
issued_count  out  CNT_WIDTH  words popped, wraps

Behaviour:
- Reset (rst=0, async): FIFO empty, out_valid=0, out_insn=0, fifo_count=0, err=0, issued_count=0. in_ready=1 because the FIFO is empty.
- Reset asserted mid-operation discards all FIFO contents immediately.
- Word assembly (combinational from the inputs, registered on push):
  - ARITH: {funct6, vm, src_2, src_1, opcode_mnr, dest, 7'h57}
  - CFG, cfg_type=0x: {1'b0, vtype_11, src_1, 3'b111, dest, 7'h57}
  - CFG, cfg_type=11: {2'b11, vtype_10, src_1, 3'b111, dest, 7'h57}
  - CFG, cfg_type=10: {1'b1, 6'b0, src_2, src_1, 3'b111, dest, 7'h57}
  - MEM: {nf, mew, mop, vm, src_2, src_1, width, dest, opcode_mjr}
- Illegal bundles, any of:
  - fmt=3
  - ARITH with opcode_mnr=3'b111
  - MEM with opcode_mjr not 7'h07 or 7'h27
- An illegal bundle is still handshaken (consumed) but not written to the FIFO. err=1 the cycle after acceptance, then 0.
- FIFO:
  - in_ready = (fifo_count < DEPTH). No bypass when full, even if out_ready=1.
  - Push: in_valid & in_ready & legal.
  - Pop: out_valid & out_ready.
  - out_valid = (fifo_count != 0). out_insn = head entry, registered.
  - Latency: a bundle accepted in cycle N appears on out_insn with out_valid in cycle N+1 at the earliest.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty: impossible (out_valid=0).
  - Read/write pointers are $clog2(DEPTH) bits and wrap naturally.
- out_insn holds its value while out_valid & !out_ready. When empty, out_insn holds the last value (don't-care).
- issued_count increments on every pop and wraps from 2^CNT_WIDTH-1 to 0.

Test Plan:
- ARITH fmt=0, funct6=0, vm=1, src_2=2, src_1=3, opcode_mnr=0, dest=1 -> next cycle out_valid=1, out_insn=0x022180D7; issued_count goes 0->1 on the pop.
- CFG vsetvli: cfg_type=00, vtype_11=0x0D0, src_1=10, dest=5 -> out_insn=0x0D0572D7.
- MEM: opcode_mjr=0x07, nf=0, mew=0, mop=0, vm=1, src_2=0, src_1=8, width=6, dest=4 -> out_insn=0x02046207.
- MEM with opcode_mjr=0x57 -> err pulses 1 cycle; FIFO count unchanged; no output word.
- With out_ready=0, push 4 bundles -> fifo_count=4, in_ready=0. Then hold in_valid=1 with out_ready=1 -> one pop per cycle, next push lands the following cycle, output order preserved, pointer wrap exercised.
- With 2 entries queued, assert rst low mid-transfer -> out_valid=0, fifo_count=0, issued_count=0 immediately (no clock edge needed).

Source files
------------

// File: rtl/insn_encoder.sv
// RVV instruction word encoder: assembles ARITH/CFG/MEM words from decoder-style field
// bundles, drops illegal bundles with a one-cycle err pulse, and queues words in a small FIFO.
module insn_encoder #(
  parameter int unsigned INSN_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                fmt,
  input  logic [6:0]                opcode_mjr,
  input  logic [2:0]                opcode_mnr,
  input  logic [4:0]                dest,
  input  logic [4:0]                src_1,
  input  logic [4:0]                src_2,
  input  logic [2:0]                width,
  input  logic [1:0]                mop,
  input  logic                      mew,
  input  logic [2:0]                nf,
  input  logic [10:0]               vtype_11,
  input  logic [9:0]                vtype_10,
  input  logic [1:0]                cfg_type,
  input  logic                      vm,
  input  logic [5:0]                funct6,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSN_WIDTH-1:0]     out_insn,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      err,
  output logic [CNT_WIDTH-1:0]      issued_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [1:0] FmtArith = 2'd0;
  localparam logic [1:0] FmtCfg   = 2'd1;
  localparam logic [1:0] FmtMem   = 2'd2;
  localparam logic [6:0] OpV      = 7'h57;
  localparam logic [6:0] OpLoadFp = 7'h07;
  localparam logic [6:0] OpStrFp  = 7'h27;

  logic [INSN_WIDTH-1:0] word;
  logic                  legal;

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt)
      FmtArith: begin
        word  = {funct6, vm, src_2, src_1, opcode_mnr, dest, OpV};
        legal = (opcode_mnr != 3'b111);
      end
      FmtCfg: begin
        legal = 1'b1;
        if (!cfg_type[1]) begin
          word = {1'b0, vtype_11, src_1, 3'b111, dest, OpV};
        end else if (cfg_type[0]) begin
          word = {2'b11, vtype_10, src_1, 3'b111, dest, OpV};
        end else begin
          word = {1'b1, 6'b0, src_2, src_1, 3'b111, dest, OpV};
        end
      end
      FmtMem: begin
        word  = {nf, mew, mop, vm, src_2, src_1, width, dest, opcode_mjr};
        legal = (opcode_mjr == OpLoadFp) || (opcode_mjr == OpStrFp);
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  logic [INSN_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q, head_ptr;
  logic [PtrW:0]         count_q, count_d;
  logic [INSN_WIDTH-1:0] out_insn_q, head_word;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic                  accept, push, pop;

  assign in_ready = (count_q != (PtrW+1)'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept   = in_valid & in_ready;
  assign push     = accept & legal;
  assign pop      = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Next head: a word pushed this cycle into the slot the head moves to must bypass the array.
  assign head_ptr  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign head_word = (push && (wr_ptr_q == head_ptr)) ? word : mem_q[head_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_insn_q <= '0;
      err_q      <= 1'b0;
      issued_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
      count_q <= count_d;
      if (count_d != '0) begin
        out_insn_q <= head_word;
      end
      err_q <= accept & ~legal;
    end
  end

  assign out_insn     = out_insn_q;
  assign fifo_count   = count_q;
  assign err          = err_q;
  assign issued_count = issued_q;

endmodule

// File: tb/tb_insn_encoder.sv
// Self-checking bench for insn_encoder: table of hand-encoded bundles, queue scoreboard,
// plus full-FIFO backpressure and asynchronous mid-transfer reset sequences.
module tb_insn_encoder;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [6:0]  opcode_mjr;
    logic [2:0]  opcode_mnr;
    logic [4:0]  dest;
    logic [4:0]  src_1;
    logic [4:0]  src_2;
    logic [2:0]  width;
    logic [1:0]  mop;
    logic        mew;
    logic [2:0]  nf;
    logic [10:0] vtype_11;
    logic [9:0]  vtype_10;
    logic [1:0]  cfg_type;
    logic        vm;
    logic [5:0]  funct6;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [6:0]  opcode_mjr = '0;
  logic [2:0]  opcode_mnr = '0;
  logic [4:0]  dest = '0, src_1 = '0, src_2 = '0;
  logic [2:0]  width = '0;
  logic [1:0]  mop = '0;
  logic        mew = 1'b0;
  logic [2:0]  nf = '0;
  logic [10:0] vtype_11 = '0;
  logic [9:0]  vtype_10 = '0;
  logic [1:0]  cfg_type = '0;
  logic        vm = 1'b0;
  logic [5:0]  funct6 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_insn;
  logic [2:0]  fifo_count;
  logic        err;
  logic [15:0] issued_count;

  insn_encoder #(.INSN_WIDTH(32), .DEPTH(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode_mjr(opcode_mjr), .opcode_mnr(opcode_mnr), .dest(dest), .src_1(src_1),
    .src_2(src_2), .width(width), .mop(mop), .mew(mew), .nf(nf), .vtype_11(vtype_11),
    .vtype_10(vtype_10), .cfg_type(cfg_type), .vm(vm), .funct6(funct6),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .fifo_count(fifo_count), .err(err), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          issued_exp = 0;
  vec_t        vecs [NV];
  vec_t        idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks against the scoreboard.
  task automatic cycle(input vec_t v, input logic iv, input logic ordy);
    logic acc, popm;
    fmt = v.fmt; opcode_mjr = v.opcode_mjr; opcode_mnr = v.opcode_mnr; dest = v.dest;
    src_1 = v.src_1; src_2 = v.src_2; width = v.width; mop = v.mop; mew = v.mew; nf = v.nf;
    vtype_11 = v.vtype_11; vtype_10 = v.vtype_10; cfg_type = v.cfg_type; vm = v.vm;
    funct6 = v.funct6; in_valid = iv; out_ready = ordy;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 4});
    chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
    popm = (sb.size() != 0) && ordy;
    acc  = iv && (sb.size() < 4);
    if (popm) begin
      chk("out_insn", out_insn, sb.pop_front());
      issued_exp++;
    end
    if (acc && v.legal) sb.push_back(v.word);
    @(posedge clk);
    #1;
    chk("err", {31'd0, err}, {31'd0, acc && !v.legal});
    chk("fifo_count", {29'd0, fifo_count}, sb.size());
    chk("issued_count", {16'd0, issued_count}, issued_exp);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() != 0; i++) cycle(idle, 1'b0, 1'b1);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    idle = '0;
    //          fmt   mjr    mnr   dest   s1     s2     wid   mop   mew   nf    vt11     vt10    ct    vm    f6     legal word
    vecs[0]  = '{2'd0, 7'h00, 3'd0, 5'd1,  5'd3,  5'd2,  3'd0, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b1, 6'h00, 1'b1, 32'h022180D7};
    vecs[1]  = '{2'd1, 7'h00, 3'd0, 5'd5,  5'd10, 5'd0,  3'd0, 2'd0, 1'b0, 3'd0, 11'h0D0, 10'h000, 2'd0, 1'b0, 6'h00, 1'b1, 32'h0D0572D7};
    vecs[2]  = '{2'd2, 7'h07, 3'd0, 5'd4,  5'd8,  5'd0,  3'd6, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b1, 6'h00, 1'b1, 32'h02046207};
    vecs[3]  = '{2'd0, 7'h13, 3'd6, 5'd31, 5'd0,  5'd31, 3'd5, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b0, 6'h3F, 1'b1, 32'hFDF06FD7};
    vecs[4]  = '{2'd1, 7'h00, 3'd0, 5'd2,  5'd7,  5'd0,  3'd0, 2'd0, 1'b0, 3'd0, 11'h000, 10'h0C3, 2'd3, 1'b0, 6'h00, 1'b1, 32'hCC33F157};
    vecs[5]  = '{2'd1, 7'h00, 3'd0, 5'd9,  5'd11, 5'd12, 3'd0, 2'd0, 1'b0, 3'd0, 11'h7FF, 10'h3FF, 2'd2, 1'b0, 6'h00, 1'b1, 32'h80C5F4D7};
    vecs[6]  = '{2'd2, 7'h27, 3'd0, 5'd3,  5'd1,  5'd5,  3'd0, 2'd2, 1'b1, 3'd7, 11'h000, 10'h000, 2'd0, 1'b0, 6'h00, 1'b1, 32'hF85081A7};
    vecs[7]  = '{2'd2, 7'h57, 3'd0, 5'd4,  5'd8,  5'd0,  3'd6, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b1, 6'h00, 1'b0, 32'h0};
    vecs[8]  = '{2'd1, 7'h00, 3'd0, 5'd0,  5'd1,  5'd0,  3'd0, 2'd0, 1'b0, 3'd0, 11'h7FF, 10'h000, 2'd1, 1'b0, 6'h00, 1'b1, 32'h7FF0F057};
    vecs[9]  = '{2'd3, 7'h07, 3'd0, 5'd1,  5'd1,  5'd1,  3'd0, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b1, 6'h00, 1'b0, 32'h0};
    vecs[10] = '{2'd0, 7'h00, 3'd7, 5'd1,  5'd3,  5'd2,  3'd0, 2'd0, 1'b0, 3'd0, 11'h000, 10'h000, 2'd0, 1'b1, 6'h00, 1'b0, 32'h0};

    // Reset values, before any clock edge leaves reset.
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_insn", out_insn, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_issued", {16'd0, issued_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Table sweep, one bundle per cycle with the consumer always ready.
    for (int i = 0; i < NV; i++) cycle(vecs[i], 1'b1, 1'b1);
    drain();

    // Fill to DEPTH with the consumer stalled, then stream with pops every cycle.
    for (int i = 0; i < 4; i++) cycle(vecs[(i + 3) % NV], 1'b1, 1'b0);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    cycle(vecs[0], 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(vecs[i % NV], 1'b1, 1'b1);
    drain();

    // Asynchronous reset with two words queued.
    cycle(vecs[1], 1'b1, 1'b0);
    cycle(vecs[2], 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_fifo_count", {29'd0, fifo_count}, 32'd0);
    chk("arst_issued", {16'd0, issued_count}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    issued_exp = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(vecs[6], 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
